// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program sequencer for a 16x16 instruction ROM (optional feature macro: FETCH_SEQ_BRANCH_EN)
module fetch_sequencer #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_inst,
    output logic [15:0] inst_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        zero_flag,
    input  logic        flag_valid,
    output logic [3:0]  pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_FLAG,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_BR   = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;

    state_t      state;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  target;
    logic [3:0]  pc_inc;

    // The ROM is addressed straight from the PC and the IR is what the decoder sees
    assign rom_addr = pc;
    assign inst_out = ir;
    assign opcode   = ir[15:12];
    assign target   = ir[3:0];
    assign pc_inc   = pc + 4'd1;

`ifndef FETCH_SEQ_BRANCH_EN
    // Flag inputs have no consumer when branches are issued as ordinary opcodes
    logic unused_flags;
    assign unused_flags = zero_flag ^ flag_valid ^ (opcode == OP_BR);
`endif

    // Sequencer FSM with registered handshake and halt outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= 16'h0000;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= rom_inst;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_JMP) begin
                        pc    <= target;
                        state <= S_FETCH;
`ifdef FETCH_SEQ_BRANCH_EN
                    end else if (opcode == OP_BR) begin
                        state <= S_WAIT_FLAG;
`endif
                    end else if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALTED;
                    end else begin
                        inst_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc         <= pc_inc;
                        state      <= S_FETCH;
                    end
                end
`ifdef FETCH_SEQ_BRANCH_EN
                S_WAIT_FLAG: begin
                    if (flag_valid) begin
                        pc    <= zero_flag ? target : pc_inc;
                        state <= S_FETCH;
                    end
                end
`endif
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks of fetch_sequencer against a program-walk model
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_inst;
    logic [15:0] inst_out;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic        flag_valid = 1'b0;
    logic [3:0]  pc;
    logic        halted;

    logic [15:0] rom [16];
    int          checks = 0;
    int          errors = 0;

    // model state: address the program would next execute from
    logic [3:0]  mpc;
    logic        mzf;

    fetch_sequencer #(.RESET_PC(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .zero_flag  (zero_flag),
        .flag_valid (flag_valid),
        .pc         (pc),
        .halted     (halted)
    );

    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // Walk the program from mpc: kind 0 = next issued word, 1 = halts, 2 = loops forever with nothing issued
    task automatic peek(output int kind, output logic [15:0] word, output logic [3:0] npc);
        logic [3:0]  p;
        logic [15:0] w;
        p    = mpc;
        kind = 2;
        word = 16'h0000;
        npc  = mpc;
        for (int k = 0; k < 40; k++) begin
            w = rom[p];
            if (w[15:12] == 4'hC) begin
                p = w[3:0];
`ifdef FETCH_SEQ_BRANCH_EN
            end else if (w[15:12] == 4'hD) begin
                p = mzf ? w[3:0] : p + 4'd1;
`endif
            end else if (w[15:12] == 4'hE) begin
                kind = 1;
                npc  = p;
                return;
            end else begin
                kind = 0;
                word = w;
                npc  = p + 4'd1;
                return;
            end
        end
    endtask

    function automatic logic [15:0] rand_word();
        int r;
        logic [3:0] ops [4];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h3; ops[3] = 4'hF;
        r = $urandom_range(0, 15);
        if (r < 2)       return {12'hC00, 4'($urandom_range(0, 15))};
        else if (r < 4)  return {12'hD00, 4'($urandom_range(0, 15))};
        else if (r == 4) return 16'hE000;
        else             return {ops[$urandom_range(0, 3)], 12'($urandom)};
    endfunction

    initial begin
        int          kind;
        logic [15:0] word;
        logic [3:0]  npc;
        logic [15:0] mid_word;

        // reset values and first-issue latency
        clear_rom();
        rom[0] = 16'h1C0A;
        inst_ready = 1'b1;
        do_reset();
        chk("rst_pc", 16'(pc), 16'h0);
        chk("rst_addr", 16'(rom_addr), 16'h0);
        chk("rst_valid", 16'(inst_valid), 16'h0);
        chk("rst_inst", inst_out, 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0);
        pulse_run();
        step();
        chk("lat_early_valid", 16'(inst_valid), 16'h0);
        step();
        chk("lat_valid", 16'(inst_valid), 16'h1);
        chk("lat_inst", inst_out, 16'h1C0A);
        step();
        chk("accept_pc", 16'(pc), 16'h1);
        chk("accept_valid", 16'(inst_valid), 16'h0);

        // backpressure in ISSUE
        rom[1] = 16'h3123;
        inst_ready = 1'b0;
        step();
        step();
        chk("bp_valid", 16'(inst_valid), 16'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 16'(inst_valid), 16'h1);
            chk("bp_hold_inst", inst_out, 16'h3123);
            chk("bp_hold_pc", 16'(pc), 16'h1);
        end
        inst_ready = 1'b1;
        step();
        chk("bp_release_pc", 16'(pc), 16'h2);

        // JMP chain: 2 -> 7, then JMP 0 at 7 is never issued
        rom[2] = 16'hC007;
        rom[7] = 16'hC000;
        step();
        chk("jmp_decode_valid", 16'(inst_valid), 16'h0);
        step();
        chk("jmp_target_pc", 16'(pc), 16'h7);
        step();
        chk("jmp7_decode_valid", 16'(inst_valid), 16'h0);
        step();
        chk("jmp7_pc", 16'(pc), 16'h0);
        step();
        step();
        chk("jmp_refetch_inst", inst_out, 16'h1C0A);
        chk("jmp_refetch_valid", 16'(inst_valid), 16'h1);

        // wrap 15 -> 0 and halt
        clear_rom();
        rom[0] = 16'hC00F;
        do_reset();
        pulse_run();
        step();
        step();
        chk("wrap_pc15", 16'(pc), 16'hF);
        step();
        step();
        chk("wrap_inst", inst_out, 16'h0000);
        chk("wrap_valid", 16'(inst_valid), 16'h1);
        rom[0] = 16'hE000;
        step();
        chk("wrap_pc0", 16'(pc), 16'h0);
        step();
        step();
        chk("halt_flag", 16'(halted), 16'h1);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_stay", 16'(halted), 16'h1);
            chk("halt_no_valid", 16'(inst_valid), 16'h0);
            chk("halt_pc", 16'(pc), 16'h0);
        end
        run = 1'b0;

        // reset while an instruction is being offered
        clear_rom();
`ifdef FETCH_SEQ_BRANCH_EN
        mid_word = 16'h1C0A;
`else
        mid_word = 16'hD008;
`endif
        rom[0] = mid_word;
        rom[1] = 16'hC001;
        inst_ready = 1'b0;
        do_reset();
        pulse_run();
        step();
        step();
        chk("mid_valid", 16'(inst_valid), 16'h1);
        chk("mid_inst", inst_out, mid_word);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 16'(inst_valid), 16'h0);
        chk("mid_rst_pc", 16'(pc), 16'h0);
        rst = 1'b0;
        step();
        chk("mid_idle_valid", 16'(inst_valid), 16'h0);
        chk("mid_idle_pc", 16'(pc), 16'h0);

`ifdef FETCH_SEQ_BRANCH_EN
        // BR 8 at 5, taken and not taken after a delayed flag
        for (int t = 0; t < 2; t++) begin
            clear_rom();
            rom[0] = 16'hC005;
            rom[5] = 16'hD008;
            zero_flag  = (t == 0);
            flag_valid = 1'b0;
            do_reset();
            pulse_run();
            step();
            step();
            step();
            step();
            for (int i = 0; i < 3; i++) begin
                step();
                chk("br_wait_pc", 16'(pc), 16'h5);
                chk("br_wait_valid", 16'(inst_valid), 16'h0);
            end
            flag_valid = 1'b1;
            step();
            flag_valid = 1'b0;
            chk("br_pc", 16'(pc), (t == 0) ? 16'h8 : 16'h6);
        end
`endif

        // randomized programs against the program-walk model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = rand_word();
            mzf = 1'($urandom);
            zero_flag = mzf;
            mpc = 4'd0;
            do_reset();
            pulse_run();
            for (int c = 0; c < 300; c++) begin
                inst_ready = ($urandom_range(0, 3) != 0);
                flag_valid = 1'($urandom);
                chk("rnd_addr", 16'(rom_addr), 16'(pc));
                if (halted) chk("rnd_halt_valid", 16'(inst_valid), 16'h0);
                if (inst_valid && inst_ready) begin
                    peek(kind, word, npc);
                    chk("rnd_kind", 16'(kind), 16'h0);
                    chk("rnd_inst", inst_out, word);
                    mpc = npc;
                end
                step();
            end
            inst_ready = 1'b0;
            flag_valid = 1'b1;
            repeat (40) step();
            peek(kind, word, npc);
            chk("rnd_end_halted", 16'(halted), 16'(kind == 1));
            chk("rnd_end_valid", 16'(inst_valid), 16'(kind == 0));
            if (kind == 0) chk("rnd_end_inst", inst_out, word);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
